// File: rtl/data_memory_responder.sv
// Data-memory responder: byte-addressed little-endian word RAM
// serving the core's held-level load/store requests in 1 or 2 beats.
module data_memory_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] memoryAddress,
  input  logic [DATA_WIDTH-1:0] memoryDataWrite,
  input  logic [1:0]            memoryLength,
  input  logic                  store,
  input  logic                  load,
  input  logic                  loadUnsigned,
  output logic [DATA_WIDTH-1:0] memoryDataRead,
  output logic                  memReady,
  output logic                  memError
);

  localparam int AW    = $clog2(DEPTH);
  localparam int BYTES = DEPTH * 4;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic        uns_q, uns_d;
  logic        ld_q, ld_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] ram [DEPTH];

  logic [31:0]   lin_addr;
  logic [31:0]   widx0;
  logic [31:0]   widx1;
  logic [1:0]    off;
  logic [AW-1:0] acc_idx;
  logic [31:0]   rd_word;
  logic [3:0]    mask4;
  logic [7:0]    mask8;
  logic [63:0]   wide_w;
  logic          straddle;
  logic [63:0]   pair;
  logic [31:0]   raw;
  logic [31:0]   ld_ext;
  logic          sgn;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wd;

  // Beat addressing, byte lanes and load alignment/extension
  always_comb begin
    lin_addr = addr_q % 32'(BYTES);
    widx0    = lin_addr >> 2;
    widx1    = (widx0 + 32'd1) % 32'(DEPTH);
    off      = lin_addr[1:0];
    acc_idx  = (state_q == BEAT1) ? AW'(widx1) : AW'(widx0);
    rd_word  = ram[acc_idx];
    mask4    = 4'b1111;
    unique case (1'b1)
      (len_q == 2'd0): mask4 = 4'b0001;
      (len_q == 2'd1): mask4 = 4'b0011;
      default:         mask4 = 4'b1111;
    endcase
    mask8    = 8'(mask4) << off;
    wide_w   = 64'(wdata_q) << {off, 3'b000};
    straddle = |mask8[7:4];
    pair     = (state_q == BEAT1) ? {rd_word, lo_q}
                                  : {32'd0, rd_word};
    raw      = 32'(pair >> {off, 3'b000});
    sgn      = 1'b0;
    ld_ext   = raw;
    unique case (1'b1)
      (len_q == 2'd0): begin
        sgn    = ~uns_q & raw[7];
        ld_ext = {{24{sgn}}, raw[7:0]};
      end
      (len_q == 2'd1): begin
        sgn    = ~uns_q & raw[15];
        ld_ext = {{16{sgn}}, raw[15:0]};
      end
      default: ld_ext = raw;
    endcase
    we = ~ld_q & ((state_q == BEAT0) | (state_q == BEAT1));
    be = (state_q == BEAT1) ? mask8[7:4] : mask8[3:0];
    wd = (state_q == BEAT1) ? wide_w[63:32] : wide_w[31:0];
  end

  // RAM byte-lane writes, one beat per cycle; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[acc_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Request FSM: capture, run beats, hold result until release
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    uns_d   = uns_q;
    ld_d    = ld_q;
    err_d   = err_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (load | store) begin
          addr_d  = memoryAddress;
          len_d   = memoryLength;
          wdata_d = memoryDataWrite;
          uns_d   = loadUnsigned;
          ld_d    = load;
          if ((load & store) | (memoryLength == 2'd3)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (straddle) begin
          lo_d    = rd_word;
          state_d = BEAT1;
        end else begin
          if (ld_q) rdata_d = ld_ext;
          state_d = DONE;
        end
      end
      BEAT1: begin
        if (ld_q) rdata_d = ld_ext;
        state_d = DONE;
      end
      DONE: begin
        if (!(load | store)) begin
          state_d = IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end else begin
          ready_d = ~err_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      uns_q   <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      uns_q   <= uns_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      lo_q    <= lo_d;
    end
  end

  assign memoryDataRead = rdata_q;
  assign memReady       = ready_q;
  assign memError       = err_q;

endmodule
